desc_stream_decoder: RTL
========================

DESC_STREAM_DECODER -- requirements
Module: desc_stream_decoder

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 16: width of the saturating error counter.
REQ-002 SHALL have parameter WORD_W, default 32: input word width; the only supported value is 32.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port s_word_valid, input, 1: input word valid.
REQ-006 SHALL have port s_word_ready, output, 1: decoder accepts a word.
REQ-007 SHALL have port s_word_data, input, 32: descriptor word.
REQ-008 SHALL have port s_word_last, input, 1: final word of the descriptor frame.
REQ-009 SHALL have port m_desc_valid, output, 1: assembled descriptor available.
REQ-010 SHALL have port m_desc_ready, input, 1: consumer accepts the descriptor.
REQ-011 SHALL have port m_desc, output, descriptor_t (256): assembled descriptor.
REQ-012 SHALL have port m_flags_dec, output, 8: one-hot flag view, bit n = flags[n] (FLAG_IS_WEIGHT .. FLAG_WRITEBACK).
REQ-013 SHALL have port err_pulse, output, 1: one-cycle pulse when a frame is rejected.
REQ-014 SHALL have port err_count, output, ERR_CNT_W: saturating count of rejected frames.

Function
REQ-015 SHALL treat a word as accepted when s_word_valid and s_word_ready are high on the same edge, and a descriptor as delivered when m_desc_valid and m_desc_ready are high on the same edge.
REQ-016 SHALL assemble words MSB-first: word 0 -> m_desc[255:224] (dram_addr) through word 7 -> m_desc[31:0].
REQ-017 SHALL use a 3-bit word index, 0 after reset, incremented on each accepted word and cleared on frame end or frame rejection.
REQ-018 SHALL implement states COLLECT, HOLD and DROP; DROP is reachable only when checks are compiled in.
REQ-019 In COLLECT, SHALL drive s_word_ready=1; when word 7 is accepted and the frame is valid, SHALL go to HOLD with m_desc_valid=1 on the next cycle (latency 1 cycle).
REQ-020 In HOLD, SHALL drive s_word_ready=0, hold m_desc stable, and return to COLLECT on delivery; if m_desc_valid and m_desc_ready are high on the edge that enters HOLD, no delivery is counted.
REQ-021 SHALL update the m_desc register only on accepted words; it is never modified in HOLD.
REQ-022 SHALL take sustained throughput as one descriptor per 9 cycles (8 accept cycles plus 1 deliver cycle).
REQ-023 SHALL increment err_count on each err_pulse and saturate it at all-ones.

Reset
REQ-024 On rst_n low, SHALL enter COLLECT with index=0, m_desc=0, m_desc_valid=0, err_pulse=0 and err_count=0.
REQ-025 SHALL drive s_word_ready=0 while rst_n is low and 1 on the first cycle after release.
REQ-026 On reset mid-frame or in HOLD, SHALL drop the partial or held descriptor without emitting it.

Configuration
REQ-027 With macro DESC_DEC_CHECK_EN defined, SHALL reject a frame at its last word and pulse err_pulse on the next cycle when any of these holds:
- s_word_last=1 at index<7: clear the index and stay in COLLECT.
- s_word_last=0 at index 7: enter DROP.
- assembled length==0.
- 17-bit sram_addr+length > 65536.
REQ-028 In DROP, SHALL hold s_word_ready=1, discard words, and return to COLLECT after accepting a word with s_word_last=1 (no second error).
REQ-029 Without DESC_DEC_CHECK_EN, SHALL ignore s_word_last, apply no checks, tie err_pulse and err_count to 0, and not implement DROP.

Structure
REQ-030 SHALL take descriptor_t, the FLAG_* bit indices and DATA_WIDTH from accelerator_common_pkg.
REQ-031 SHALL add a desc_dec_state_t enum (COLLECT, HOLD, DROP) to accelerator_common_pkg.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 Eight back-to-back words 0x8000_0000, 0x0100_0040, 0x0010_0000, 0, 0, 0x0008_0008, 0x0003_C100, 0 (last on word 7), m_desc_ready=1 -> m_desc_valid one cycle after word 7; dram_addr=0x8000_0000, sram_addr=0x0100, length=0x0040, flags=0xC1, m_flags_dec=0xC1.
REQ-034 Same frame with m_desc_ready=0 for 5 cycles -> m_desc stable, s_word_ready=0 throughout, delivery on the 6th cycle, then COLLECT.
REQ-035 (CHECK_EN) s_word_last on word 3 -> err_pulse=1, err_count=1, no m_desc_valid; the next 8-word frame decodes correctly.
REQ-036 (CHECK_EN) 8 words without last, then 2 words with last on the second -> one err_pulse, DROP exits, the following frame decodes.
REQ-037 (CHECK_EN) sram_addr=0xFFF0, length=0x0020 -> rejected; err_count saturates at 0xFFFF after 65536+ such frames.
REQ-038 rst_n pulsed low after word 4 -> no output; the fresh frame then assembles from word 0.

Source files
------------

// File: rtl/accelerator_common_pkg.sv
// Shared accelerator types: descriptor layout, flag bit indices and the
// descriptor stream decoder state encoding.
package accelerator_common_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DESC_WORDS = 8;

  // Bit positions inside descriptor_t.flags
  localparam int unsigned FLAG_IS_WEIGHT = 0;
  localparam int unsigned FLAG_IS_ACT    = 1;
  localparam int unsigned FLAG_IS_BIAS   = 2;
  localparam int unsigned FLAG_RELU      = 3;
  localparam int unsigned FLAG_POOL      = 4;
  localparam int unsigned FLAG_LAST_TILE = 5;
  localparam int unsigned FLAG_IRQ       = 6;
  localparam int unsigned FLAG_WRITEBACK = 7;

  // 256-bit descriptor, word 0 in the top 32 bits
  typedef struct packed {
    logic [31:0] dram_addr;   // word 0
    logic [15:0] sram_addr;   // word 1 [31:16]
    logic [15:0] length;      // word 1 [15:0]
    logic [31:0] dram_stride; // word 2
    logic [15:0] tile_h;      // word 3 [31:16]
    logic [15:0] tile_w;      // word 3 [15:0]
    logic [31:0] reserved0;   // word 4
    logic [15:0] in_ch;       // word 5 [31:16]
    logic [15:0] out_ch;      // word 5 [15:0]
    logic [15:0] layer_id;    // word 6 [31:16]
    logic [7:0]  flags;       // word 6 [15:8]
    logic [7:0]  opcode;      // word 6 [7:0]
    logic [31:0] next_desc;   // word 7
  } descriptor_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DROP    = 2'd2
  } desc_dec_state_t;

endpackage

// File: rtl/desc_stream_decoder.sv
// Descriptor stream decoder: packs eight 32-bit words (MSB word first) into a
// descriptor_t and offers it on a valid/ready output.
// Optional frame checks are compiled in with `define DESC_DEC_CHECK_EN.
module desc_stream_decoder
  import accelerator_common_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16,
  parameter int unsigned WORD_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_word_valid,
  output logic                 s_word_ready,
  input  logic [WORD_W-1:0]    s_word_data,
  input  logic                 s_word_last,
  output logic                 m_desc_valid,
  input  logic                 m_desc_ready,
  output descriptor_t          m_desc,
  output logic [7:0]           m_flags_dec,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  desc_dec_state_t state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic       accept;
  logic       load;
  logic [DESC_WORDS-1:0][DATA_WIDTH-1:0] words;

  assign s_word_ready = rst_n && (state != HOLD);
  assign accept       = s_word_valid && s_word_ready;
  assign m_desc_valid = (state == HOLD);
  assign m_desc       = descriptor_t'(words);
  assign m_flags_dec  = m_desc.flags;

`ifdef DESC_DEC_CHECK_EN
  logic        reject;
  logic [16:0] span;
  logic        range_bad;

  // sram_addr/length come from word 1, already registered when word 7 arrives
  assign span      = {1'b0, m_desc.sram_addr} + {1'b0, m_desc.length};
  assign range_bad = (m_desc.length == '0) || (span > 17'h10000);
`else
  logic unused_last;
  assign unused_last = s_word_last;
`endif

  // Next-state, word index and load decisions
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
`ifdef DESC_DEC_CHECK_EN
    reject    = 1'b0;
`endif
    case (state)
      COLLECT: begin
        if (accept) begin
          load    = 1'b1;
          idx_nxt = idx + 3'd1;
`ifdef DESC_DEC_CHECK_EN
          if (idx == 3'd7) begin
            idx_nxt = '0;
            if (!s_word_last) begin
              reject    = 1'b1;
              state_nxt = DROP;
            end else if (range_bad) begin
              reject = 1'b1;
            end else begin
              state_nxt = HOLD;
            end
          end else if (s_word_last) begin
            reject  = 1'b1;
            idx_nxt = '0;
          end
`else
          if (idx == 3'd7) begin
            idx_nxt   = '0;
            state_nxt = HOLD;
          end
`endif
        end
      end
      HOLD: begin
        if (m_desc_ready) state_nxt = COLLECT;
      end
`ifdef DESC_DEC_CHECK_EN
      DROP: begin
        if (accept && s_word_last) state_nxt = COLLECT;
      end
`endif
      default: state_nxt = COLLECT;
    endcase
  end

  // State and word index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Descriptor storage, written only on words accepted in COLLECT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words <= '0;
    end else if (load) begin
      words[3'd7 - idx] <= s_word_data;
    end
  end

`ifdef DESC_DEC_CHECK_EN
  // Rejection pulse and saturating reject counter, updated together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= reject;
      if (reject && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`else
  assign err_pulse = 1'b0;
  assign err_count = '0;
`endif

endmodule
